// File: rtl/game_monitor_if.sv
// Bird/pipe column sampling and score display bundle for game_monitor.
// The master side drives the play inputs; the slave side returns status and score.
interface game_monitor_if #(
  parameter int ROWS = 16
);
  logic            start;
  logic [ROWS-1:0] bird_col;
  logic [ROWS-1:0] pipe_col;
  logic            pipe_shift;
  logic            active;
  logic            gameover;
  logic [3:0]      score_ones;
  logic [3:0]      score_tens;
  logic [3:0]      best_ones;
  logic [3:0]      best_tens;

  modport master (
    output start, bird_col, pipe_col, pipe_shift,
    input  active, gameover,
    input  score_ones, score_tens,
    input  best_ones, best_tens
  );

  modport slave (
    input  start, bird_col, pipe_col, pipe_shift,
    output active, gameover,
    output score_ones, score_tens,
    output best_ones, best_tens
  );
endinterface

// File: rtl/game_monitor.sv
// Game flow FSM, collision detect and 2-digit BCD score for the bird game.
// Define HIGH_SCORE_EN to keep a best score across games.
module game_monitor #(
  parameter int ROWS = 16
) (
  input logic          clk,
  input logic          reset,
  game_monitor_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_t;

  state_t     state, state_n;
  logic       start_q;
  logic       start_rise;
  logic       hit;
  logic       safe_shift;
  logic       clr, inc;
  logic       active_q, active_n;
  logic       over_q, over_n;
  logic [3:0] s_ones, s_tens;
  logic       at_max;

  assign start_rise = bus.start & ~start_q;

  // A bird that left the field counts as a collision.
  assign hit = (|(bus.bird_col & bus.pipe_col))
             | (bus.bird_col == '0);

  assign safe_shift = bus.pipe_shift
                    & (bus.pipe_col != '0);

  assign at_max = (s_tens == 4'd9)
                & (s_ones == 4'd9);

  always_comb begin
    state_n  = state;
    clr      = 1'b0;
    inc      = 1'b0;
    active_n = 1'b0;
    over_n   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (start_rise) begin
          state_n = PLAY;
          clr     = 1'b1;
        end
      end
      (state == PLAY): begin
        if (hit)
          state_n = OVER;
        else if (safe_shift)
          inc = 1'b1;
      end
      (state == OVER): begin
        if (start_rise)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    active_n = (state_n != IDLE);
    over_n   = (state_n == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      over_q   <= 1'b0;
      s_ones   <= 4'd0;
      s_tens   <= 4'd0;
    end else begin
      state    <= state_n;
      start_q  <= bus.start;
      active_q <= active_n;
      over_q   <= over_n;
      if (clr) begin
        s_ones <= 4'd0;
        s_tens <= 4'd0;
      end else if (inc && !at_max) begin
        if (s_ones == 4'd9) begin
          s_ones <= 4'd0;
          s_tens <= s_tens + 4'd1;
        end else begin
          s_ones <= s_ones + 4'd1;
        end
      end
    end
  end

  assign bus.active     = active_q;
  assign bus.gameover   = over_q;
  assign bus.score_ones = s_ones;
  assign bus.score_tens = s_tens;

`ifdef HIGH_SCORE_EN
  logic [3:0] b_ones, b_tens;
  logic       pend;

  // BCD digits compare correctly as a plain 8-bit magnitude.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend   <= 1'b0;
      b_ones <= 4'd0;
      b_tens <= 4'd0;
    end else begin
      pend <= (state == PLAY) & hit;
      if (pend && ({s_tens, s_ones} > {b_tens, b_ones})) begin
        b_ones <= s_ones;
        b_tens <= s_tens;
      end
    end
  end

  assign bus.best_ones = b_ones;
  assign bus.best_tens = b_tens;
`else
  assign bus.best_ones = 4'd0;
  assign bus.best_tens = 4'd0;
`endif

endmodule

// File: tb/tb_game_monitor.sv
// Self-checking bench for game_monitor: vector table, directed corners,
// and random play against a score/game reference model.
module tb_game_monitor;
  localparam int ROWS = 16;

  logic clk;
  logic reset;

  game_monitor_if #(.ROWS(ROWS)) bus ();

  game_monitor #(.ROWS(ROWS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // reference model
  bit m_startq;
  bit m_play;
  bit m_over;
  bit m_pend;
  int m_score;
  int m_best;

  typedef struct {
    bit        rst;
    bit        start;
    bit [15:0] bird;
    bit [15:0] pipe;
    bit        shift;
    bit        e_act;
    bit        e_over;
    int        e_score;
    int        e_best;
  } vec_t;

  vec_t vec[14];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dut_score();
    return bus.score_tens * 10 + bus.score_ones;
  endfunction

  function automatic int dut_best();
    return bus.best_tens * 10 + bus.best_ones;
  endfunction

  task automatic model_edge(input bit r, input bit s,
                            input bit [15:0] b, input bit [15:0] p,
                            input bit sh);
    bit rise, h;
    if (r) begin
      m_startq = 0; m_play = 0; m_over = 0;
      m_pend = 0; m_score = 0; m_best = 0;
      return;
    end
    rise = s && !m_startq;
    m_startq = s;
    h = ((b & p) != 0) || (b == 0);
    if (m_pend) begin
      if (m_score > m_best) m_best = m_score;
      m_pend = 0;
    end
    if (m_play) begin
      if (h) begin
        m_play = 0; m_over = 1; m_pend = 1;
      end else if (sh && p != 0 && m_score < 99) begin
        m_score++;
      end
    end else if (m_over) begin
      if (rise) m_over = 0;
    end else if (rise) begin
      m_play = 1; m_score = 0;
    end
  endtask

  task automatic drive(input bit r, input bit s,
                       input bit [15:0] b, input bit [15:0] p,
                       input bit sh);
    reset          = r;
    bus.start      = s;
    bus.bird_col   = b;
    bus.pipe_col   = p;
    bus.pipe_shift = sh;
    @(posedge clk);
    model_edge(r, s, b, p, sh);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    int eb;
`ifdef HIGH_SCORE_EN
    eb = m_best;
`else
    eb = 0;
`endif
    chk({tag, " active"}, int'(bus.active), int'(m_play || m_over));
    chk({tag, " gameover"}, int'(bus.gameover), int'(m_over));
    chk({tag, " score"}, dut_score(), m_score);
    chk({tag, " best"}, dut_best(), eb);
  endtask

  task automatic step(input string tag, input bit r, input bit s,
                      input bit [15:0] b, input bit [15:0] p,
                      input bit sh);
    drive(r, s, b, p, sh);
    check_model(tag);
  endtask

  initial begin
    int eb;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.start      = 1'b0;
    bus.bird_col   = '0;
    bus.pipe_col   = '0;
    bus.pipe_shift = 1'b0;
    @(negedge clk);

    //           rst st bird      pipe      sh act ov sc best
    vec[0]  = '{1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 1, 16'h0010, 16'h0000, 0, 1, 0, 0, 0};
    vec[2]  = '{0, 1, 16'h0010, 16'h0000, 0, 1, 0, 0, 0};
    vec[3]  = '{0, 1, 16'h0010, 16'h0000, 0, 1, 0, 0, 0};
    vec[4]  = '{0, 0, 16'h0010, 16'hFF0F, 1, 1, 0, 1, 0};
    vec[5]  = '{0, 0, 16'h0010, 16'h0000, 1, 1, 0, 1, 0};
    vec[6]  = '{0, 0, 16'h0100, 16'h0100, 1, 1, 1, 1, 0};
    vec[7]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 1};
    vec[8]  = '{0, 1, 16'h0000, 16'hFFFF, 1, 0, 0, 1, 1};
    vec[9]  = '{0, 0, 16'h0000, 16'hFFFF, 1, 0, 0, 1, 1};
    vec[10] = '{0, 1, 16'h0001, 16'h0000, 0, 1, 0, 0, 1};
    vec[11] = '{0, 0, 16'h0000, 16'h0002, 1, 1, 1, 0, 1};
    vec[12] = '{0, 0, 16'h0001, 16'h0002, 1, 1, 1, 0, 1};
    vec[13] = '{1, 1, 16'h0001, 16'h0002, 1, 0, 0, 0, 0};

    for (int i = 0; i < 14; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(vec[i].rst, vec[i].start, vec[i].bird,
            vec[i].pipe, vec[i].shift);
`ifdef HIGH_SCORE_EN
      eb = vec[i].e_best;
`else
      eb = 0;
`endif
      chk({t, " active"}, int'(bus.active), int'(vec[i].e_act));
      chk({t, " gameover"}, int'(bus.gameover), int'(vec[i].e_over));
      chk({t, " score"}, dut_score(), vec[i].e_score);
      chk({t, " best"}, dut_best(), eb);
    end

    // saturation: 100 safe shifts from 00
    step("sat rst", 1, 0, 16'h0001, 16'h0000, 0);
    step("sat go", 0, 1, 16'h0001, 16'h0000, 0);
    for (int i = 1; i <= 100; i++) begin
      drive(0, 0, 16'h0001, 16'hFFF0, 1);
      if (i == 9)   chk("sat 09", dut_score(), 9);
      if (i == 10)  chk("sat 10", dut_score(), 10);
      if (i == 99)  chk("sat 99", dut_score(), 99);
      if (i == 100) chk("sat hold", dut_score(), 99);
    end
    check_model("sat end");
    step("sat idle", 0, 0, 16'h0001, 16'hFFF0, 0);
    chk("sat nowrap", dut_score(), 99);

    // two games: 05 then 03, then reset mid-play
    step("hs rst", 1, 0, 16'h0001, 16'h0000, 0);
    for (int g = 0; g < 2; g++) begin
      int n;
      n = (g == 0) ? 5 : 3;
      step("hs go", 0, 1, 16'h0001, 16'h0000, 0);
      for (int i = 0; i < n; i++)
        step("hs shift", 0, 0, 16'h0001, 16'h0F00, 1);
      step("hs hit", 0, 0, 16'h0800, 16'h0F00, 0);
      chk("hs over", int'(bus.gameover), 1);
      step("hs settle", 0, 0, 16'h0800, 16'h0F00, 0);
      step("hs exit", 0, 0, 16'h0800, 16'h0F00, 0);
      step("hs exit", 0, 1, 16'h0800, 16'h0F00, 0);
      step("hs low", 0, 0, 16'h0800, 16'h0F00, 0);
    end
`ifdef HIGH_SCORE_EN
    chk("hs best", dut_best(), 5);
`else
    chk("hs best", dut_best(), 0);
`endif
    step("hs go3", 0, 1, 16'h0001, 16'h0000, 0);
    step("hs sh3", 0, 0, 16'h0001, 16'h0F00, 1);
    step("hs midrst", 1, 1, 16'h0001, 16'h0F00, 1);
    chk("rst active", int'(bus.active), 0);
    chk("rst score", dut_score(), 0);
    chk("rst best", dut_best(), 0);

    // random play against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, s, sh;
      bit [15:0] b, p;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 9) == 0) ? ~bus.start : bus.start;
      sh = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0)
        b = 16'h0000;
      else
        b = 16'h0001 << $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: p = 16'h0000;
        1: p = 16'($urandom);
        default: p = ~b & 16'($urandom);
      endcase
      step($sformatf("rnd%0d", i), r, s, b, p, sh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
